// File: rtl/out_port_sched.sv
// Output-port scheduler: round-robin over NUM_Q queue managers, pops a length
// descriptor and streams that many bytes out as sof/dv/eof. Option: OUT_SCHED_STRICT_PRIO_EN.
module out_port_sched #(
    parameter int NUM_Q = 4,
    parameter int LEN_W = 12,
    parameter int IFG   = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_Q-1:0]     ptr_fifo_empty,
    output logic [NUM_Q-1:0]     ptr_fifo_rd,
    input  logic [16*NUM_Q-1:0]  ptr_fifo_dout,
    output logic [NUM_Q-1:0]     data_fifo_rd,
    input  logic [8*NUM_Q-1:0]   data_fifo_dout,
    input  logic                 tx_ready,
    output logic                 tx_sof,
    output logic                 tx_dv,
    output logic [7:0]           tx_data,
    output logic                 tx_eof,
    output logic [NUM_Q-1:0]     grant,
    output logic                 busy,
    output logic                 err_zero_len
);

    localparam int PW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam logic [3:0] GAP_LAST = (IFG > 0) ? 4'(IFG - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        PTR_RD,
        PTR_WAIT,
        XFER,
        DRAIN,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    rr_ptr, rr_nxt;
    logic [PW-1:0]    g_idx, g_nxt;
    logic [NUM_Q-1:0] grant_nxt;
    logic [LEN_W-1:0] rem, rem_nxt;
    logic [3:0]       gap_cnt, gap_nxt;
    logic             first_pend, first_nxt;
    logic             dv_q, sof_q, eof_q;
    logic             rd_now;
    logic [LEN_W-1:0] desc_len;
    logic             sel_vld;
    logic [PW-1:0]    sel_idx, cand;
    int unsigned      idx;
    logic             unused_desc;

    assign desc_len    = ptr_fifo_dout[16*32'(g_idx) +: LEN_W];
    assign unused_desc = ^ptr_fifo_dout;

    // Strict priority is the same scan with rr_ptr pinned at 0.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_Q) idx = idx - NUM_Q;
            cand = PW'(idx);
            if (!sel_vld && !ptr_fifo_empty[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr_ptr;
        g_nxt        = g_idx;
        grant_nxt    = grant;
        rem_nxt      = rem;
        gap_nxt      = gap_cnt;
        first_nxt    = first_pend;
        rd_now       = 1'b0;
        err_zero_len = 1'b0;
        ptr_fifo_rd  = '0;
        data_fifo_rd = '0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    g_nxt     = sel_idx;
                    grant_nxt = NUM_Q'(1) << sel_idx;
                    state_nxt = PTR_RD;
                end
            end
            PTR_RD: begin
                ptr_fifo_rd = grant;
                state_nxt   = PTR_WAIT;
            end
            PTR_WAIT: begin
                rem_nxt   = desc_len;
                first_nxt = 1'b1;
                if (desc_len == '0) begin
                    err_zero_len = 1'b1;
                    grant_nxt    = '0;
                    gap_nxt      = '0;
                    state_nxt    = (IFG == 0) ? IDLE : GAP;
                end else begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (tx_ready && rem != '0) begin
                    rd_now       = 1'b1;
                    data_fifo_rd = grant;
                    rem_nxt      = rem - 1'b1;
                    first_nxt    = 1'b0;
                    if (rem == LEN_W'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
`ifndef OUT_SCHED_STRICT_PRIO_EN
                if (32'(g_idx) == NUM_Q - 1) rr_nxt = '0;
                else                         rr_nxt = g_idx + 1'b1;
`endif
                grant_nxt = '0;
                gap_nxt   = '0;
                state_nxt = (IFG == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
                else                     gap_nxt   = gap_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            g_idx      <= '0;
            grant      <= '0;
            rem        <= '0;
            gap_cnt    <= '0;
            first_pend <= 1'b0;
            dv_q       <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            g_idx      <= g_nxt;
            grant      <= grant_nxt;
            rem        <= rem_nxt;
            gap_cnt    <= gap_nxt;
            first_pend <= first_nxt;
            dv_q       <= rd_now;
            sof_q      <= rd_now && first_pend;
            eof_q      <= rd_now && (rem == LEN_W'(1));
        end
    end

    // Data FIFO has one cycle of read latency, so the byte is taken straight from dout.
    assign tx_dv   = dv_q;
    assign tx_sof  = sof_q;
    assign tx_eof  = eof_q;
    assign tx_data = dv_q ? data_fifo_dout[8*32'(g_idx) +: 8] : 8'h00;
    assign busy    = (state != IDLE);

endmodule
